stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Sequencing controller for the seconds-counting datapath: a one-second prescaler followed by two cascaded BCD digit counters (ones 0-9, tens 0..MAX_TENS).
- Owns the run/pause/clear state machine and gates the prescaler and digit counters.
- Feeds the 7-segment decoders (one per digit) and emits tick and wrap strobes for downstream logic.

Parameters:
- TICK_DIV, 50000000: CLOCK_50 cycles per count step (one second at 50 MHz); must be >= 2.
- MAX_TENS, 5: terminal value of the tens digit (5 gives a 00-59 count); range 1-9.

Ports:
- CLOCK_50  in   1  system clock; all state changes on its rising edge.
- reset     in   1  asynchronous, active-high reset.
- start_stop in  1  single-cycle synchronous pulse; toggles run/pause.
- clear     in   1  single-cycle synchronous pulse; returns to IDLE with count zeroed.
- lap       in   1  single-cycle synchronous pulse; used only with LAP_EN.
- ones      out  4  BCD ones digit, 0-9.
- tens      out  4  BCD tens digit, 0..MAX_TENS.
- running   out  1  high while state is RUN.
- tick      out  1  one-cycle pulse, one cycle after each count step.
- wrap      out  1  one-cycle pulse, one cycle after the terminal-to-00 step.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, prescaler=0, ones=0, tens=0.
  - running=0, tick=0, wrap=0, lap freeze cleared.
- States:
  - IDLE: prescaler held at 0; digits held at 00.
  - RUN: prescaler counts.
  - PAUSE: prescaler and digits hold their values.
- Transitions (evaluated on each rising edge):
  - clear=1: any state -> IDLE; prescaler=0, digits=00. clear takes priority over start_stop and lap in the same cycle.
  - start_stop=1, clear=0: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - Otherwise: state holds.
- Prescaler (width ceil(log2(TICK_DIV))):
  - In RUN, increments 0..TICK_DIV-1.
  - On the edge where it equals TICK_DIV-1, it wraps to 0 and a count step occurs.
  - PAUSE keeps the partial count, so a resume finishes the interrupted second. It is not reset on PAUSE->RUN.
- Count step:
  - ones<9: ones+1.
  - ones=9, tens<MAX_TENS: ones=0, tens+1.
  - ones=9, tens=MAX_TENS: ones=0, tens=0; this is the terminal step.
- Step decision uses the current state. If start_stop arrives on a step edge while in RUN, the step still occurs and the state becomes PAUSE.
- Strobes:
  - tick is registered: high for exactly one cycle following a step edge.
  - wrap is likewise registered and coincides with tick on terminal steps.
  - Both are 0 in IDLE/PAUSE except for the cycle after a step.
- running is registered, equal to (state==RUN).
- Latency: from the edge that samples start_stop in IDLE, the first step occurs TICK_DIV edges later; the matching tick is high one cycle after that.
- Digits never hold non-BCD values; any illegal value is unreachable from reset.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - A lap pulse while running=1 freezes ones/tens at their current values; internal counting continues.
  - A second lap pulse releases the freeze, and outputs jump to the live count.
  - lap in IDLE or PAUSE toggles the freeze only if it is already frozen (release only).
  - clear or reset releases the freeze.
  - tick and wrap are never frozen.
- Not defined:
  - The lap port exists but is ignored.
  - ones/tens always show the live count.

Test Plan:
- TICK_DIV=4: assert reset mid-RUN at digits 37 -> ones=0, tens=0, running=0, tick=0 before the next clock edge.
- TICK_DIV=4: start_stop pulse at edge N -> running=1 after N; digits 01 after edge N+4; tick high for exactly the cycle after N+4; digits 02 after N+8.
- TICK_DIV=4, MAX_TENS=5, digits at 59 in RUN -> next step gives 00, tick=1 and wrap=1 together for one cycle; step 08->09->10 shows the ones-to-tens carry with wrap=0.
- TICK_DIV=4: pause with prescaler=2 at digits 14 -> digits hold for 20 cycles; resume -> 15 appears 2 edges after resume edge, not 4.
- clear and start_stop pulsed in the same cycle while in RUN at 42 -> state IDLE, digits 00, running=0; a following start_stop starts from 00.
- STOPWATCH_LAP_EN, TICK_DIV=4: lap at 05 -> outputs hold 05 while tick keeps pulsing; lap again after 3 steps -> outputs show 08.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: control pulses in, BCD digits and status strobes out
//   start_stop, clear, lap : single-cycle command pulses (master -> slave)
//   ones, tens             : BCD digits shown on the display
//   running, tick, wrap    : registered status and one-cycle count strobes
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       running;
  logic       tick;
  logic       wrap;
  modport master (output start_stop, clear, lap, input ones, tens, running, tick, wrap);
  modport slave (input start_stop, clear, lap, output ones, tens, running, tick, wrap);
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer for a prescaled two-digit BCD seconds counter
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous active-high reset
//   sw       : stopwatch_ctrl_if.slave (commands in, digits/running/tick/wrap out)
//   STOPWATCH_LAP_EN : when defined, lap freezes the displayed digits while counting continues
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int MAX_TENS = 5
) (
  input logic CLOCK_50,
  input logic reset,
  stopwatch_ctrl_if.slave sw
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [PW-1:0] pre;
  logic [3:0] ones_q, tens_q;
  logic running_q, tick_q, wrap_q;
  logic last, step, term;
  assign last = pre == PW'(TICK_DIV - 1);
  assign step = state == RUN && last;
  assign term = ones_q == 4'd9 && tens_q == 4'(MAX_TENS);
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= IDLE;
      pre <= '0;
      ones_q <= '0;
      tens_q <= '0;
      running_q <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (sw.clear) begin
      state <= IDLE;
      pre <= '0;
      ones_q <= '0;
      tens_q <= '0;
      running_q <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      // step uses the current state, so a pause arriving on a step edge still counts
      if (sw.start_stop) state <= state == RUN ? PAUSE : RUN;
      running_q <= sw.start_stop ? state != RUN : state == RUN;
      if (state == RUN) pre <= last ? '0 : pre + PW'(1);
      if (step) begin
        ones_q <= ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1;
        tens_q <= ones_q != 4'd9 ? tens_q : term ? 4'd0 : tens_q + 4'd1;
      end
      tick_q <= step;
      wrap_q <= step && term;
    end
`ifdef STOPWATCH_LAP_EN
  logic frozen;
  logic [3:0] lap_ones, lap_tens;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      frozen <= 1'b0;
      lap_ones <= '0;
      lap_tens <= '0;
    end else if (sw.clear) begin
      frozen <= 1'b0;
    end else if (sw.lap && (running_q || frozen)) begin
      // outside RUN a lap can only release an existing freeze
      frozen <= !frozen;
      lap_ones <= ones_q;
      lap_tens <= tens_q;
    end
  assign sw.ones = frozen ? lap_ones : ones_q;
  assign sw.tens = frozen ? lap_tens : tens_q;
`else
  assign sw.ones = ones_q;
  assign sw.tens = tens_q;
`endif
  assign sw.running = running_q;
  assign sw.tick = tick_q;
  assign sw.wrap = wrap_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of stopwatch_ctrl with TICK_DIV=4, MAX_TENS=5
module tb_stopwatch_ctrl;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  stopwatch_ctrl_if sw ();
  stopwatch_ctrl #(.TICK_DIV(4), .MAX_TENS(5)) dut (.CLOCK_50(clk), .reset(rst), .sw(sw));
  always #5 clk = !clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic digits(input string tag, input logic [7:0] exp);
    chk(tag, {sw.tens, sw.ones}, exp);
  endtask
  task automatic pulse_ss();
    sw.start_stop = 1'b1;
    cyc(1);
    sw.start_stop = 1'b0;
  endtask
  task automatic pulse_lap();
    sw.lap = 1'b1;
    cyc(1);
    sw.lap = 1'b0;
  endtask
  initial begin
    sw.start_stop = 1'b0;
    sw.clear = 1'b0;
    sw.lap = 1'b0;
    cyc(3);
    digits("reset_digits", 8'h00);
    chk("reset_status", {5'd0, sw.running, sw.tick, sw.wrap}, 8'h00);
    rst = 1'b0;
    cyc(2);
    pulse_ss();
    chk("start_running", {7'd0, sw.running}, 8'h01);
    cyc(3);
    digits("pre_first_step", 8'h00);
    chk("pre_first_tick", {7'd0, sw.tick}, 8'h00);
    cyc(1);
    digits("first_step", 8'h01);
    chk("first_tick", {6'd0, sw.tick, sw.wrap}, 8'h02);
    cyc(1);
    chk("tick_one_cycle", {7'd0, sw.tick}, 8'h00);
    cyc(3);
    digits("second_step", 8'h02);
    chk("second_tick", {7'd0, sw.tick}, 8'h01);
    cyc(24);
    digits("at_08", 8'h08);
    cyc(4);
    digits("at_09", 8'h09);
    cyc(4);
    digits("carry_10", 8'h10);
    chk("carry_strobes", {6'd0, sw.tick, sw.wrap}, 8'h02);
    cyc(16);
    digits("at_14", 8'h14);
    cyc(1);
    pulse_ss();
    chk("paused", {7'd0, sw.running}, 8'h00);
    cyc(20);
    digits("pause_hold", 8'h14);
    chk("pause_no_tick", {7'd0, sw.tick}, 8'h00);
    pulse_ss();
    chk("resumed", {7'd0, sw.running}, 8'h01);
    cyc(1);
    digits("resume_partial", 8'h14);
    cyc(1);
    digits("resume_15", 8'h15);
    chk("resume_tick", {7'd0, sw.tick}, 8'h01);
    cyc(88);
    digits("at_37", 8'h37);
    #2 rst = 1'b1;
    #1;
    digits("async_reset_digits", 8'h00);
    chk("async_reset_status", {5'd0, sw.running, sw.tick, sw.wrap}, 8'h00);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    pulse_ss();
    cyc(168);
    digits("at_42", 8'h42);
    sw.clear = 1'b1;
    sw.start_stop = 1'b1;
    cyc(1);
    sw.clear = 1'b0;
    sw.start_stop = 1'b0;
    digits("clear_digits", 8'h00);
    chk("clear_status", {6'd0, sw.running, sw.tick}, 8'h00);
    cyc(5);
    digits("idle_hold", 8'h00);
    pulse_ss();
    cyc(4);
    digits("restart_01", 8'h01);
    cyc(232);
    digits("at_59", 8'h59);
    chk("at_59_wrap", {7'd0, sw.wrap}, 8'h00);
    cyc(4);
    digits("wrap_00", 8'h00);
    chk("wrap_strobes", {6'd0, sw.tick, sw.wrap}, 8'h03);
    cyc(1);
    chk("wrap_one_cycle", {6'd0, sw.tick, sw.wrap}, 8'h00);
    sw.clear = 1'b1;
    cyc(1);
    sw.clear = 1'b0;
    pulse_ss();
    cyc(20);
    digits("lap_at_05", 8'h05);
    pulse_lap();
    digits("lap_capture", 8'h05);
    cyc(3);
    digits("lap_frozen_06", LAP ? 8'h05 : 8'h06);
    chk("lap_tick_runs", {7'd0, sw.tick}, 8'h01);
    cyc(8);
    digits("lap_frozen_08", LAP ? 8'h05 : 8'h08);
    chk("lap_tick_08", {7'd0, sw.tick}, 8'h01);
    pulse_lap();
    digits("lap_release", 8'h08);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
